gpio_access_arbiter: RTL and testbench
======================================

Name: gpio_access_arbiter

Overview:
Two-port arbiter and access sequencer in front of the GPIO register file's single register port (gpio_we / gpio_addr / gpio_dat_i / gpio_dat_o). It shares that port between two requesters, typically the APB slave front-end (port 0) and the on-chip test/debug sequencer (port 1), using round-robin arbitration. Each access runs as a fixed 4-state sequence. Illegal accesses are rejected with an error before they reach the register file.

Parameters:
MAX_ADDR, 32'h24, highest legal register byte address (inclusive)
RO_ADDR, 32'h00, address of the read-only input register; writes to it are rejected

Ports:
sys_clk  input  1  clock; all logic on rising edge
sys_rst  input  1  asynchronous, active-high reset
r0_req  input  1  port 0 request; held high until r0_ack
r0_we  input  1  port 0 write (1) / read (0); stable while r0_req
r0_addr  input  32  port 0 byte address; stable while r0_req
r0_wdata  input  32  port 0 write data; stable while r0_req
r0_ack  output  1  port 0 completion, one-cycle pulse
r0_err  output  1  port 0 error, valid with r0_ack, held until next r0_ack
r0_rdata  output  32  port 0 read data, valid with r0_ack, held until next r0_ack
r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same as port 0, for port 1
gpio_we  output  1  write strobe to register file
gpio_addr  output  32  register address to register file
gpio_dat_i  output  32  write data to register file
gpio_dat_o  input  32  combinational readback from register file
busy  output  1  high in any state other than IDLE
grant_id  output  1  port owning the current or most recent transaction

Behaviour:
- Reset: state IDLE. All outputs 0, including gpio_addr, gpio_dat_i, both rdata, both err, grant_id. Round-robin pointer last=1, so port 0 wins the first tie.
- FSM: IDLE -> SETUP -> ACCESS -> ACK -> IDLE. Every transaction takes exactly 4 cycles and there are no wait states.
- IDLE:
  - If any req is high, select the winner, latch its we/addr/wdata, set grant_id, set last=winner, and go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester: that port wins.
  - Both requesting: the port != last wins (strict alternation under continuous contention).
- Address check on the latched address, evaluated in SETUP:
  - Legal when addr[1:0]==0 and addr<=MAX_ADDR.
  - A write is additionally illegal when addr==RO_ADDR.
- SETUP: gpio_addr = latched addr and gpio_dat_i = latched wdata, both registered outputs. gpio_we=0.
- ACCESS:
  - gpio_we=1 for exactly this one cycle, only if the access is a legal write.
  - For a legal read, capture gpio_dat_o into the granted port's rdata at the end of the cycle.
  - gpio_addr and gpio_dat_i are unchanged.
- ACK:
  - Granted port's ack=1 for one cycle.
  - err=1 if the access was illegal, otherwise 0.
  - Illegal reads return rdata=0. Writes leave that port's rdata unchanged.
  - The other port's outputs are untouched.
- Latency: req high in IDLE at cycle t -> ack high at cycle t+3.
- After IDLE: gpio_addr and gpio_dat_i hold their last values; gpio_we=0.
- Requester protocol:
  - After ack, a requester may keep req high for back-to-back transactions. The next arbitration happens in the IDLE cycle following ACK.
  - A port's req is never sampled while that port owns the bus.
- req dropped mid-transaction: the transaction is not aborted. The access completes and ack still pulses.
- Simultaneous new request and ACK: no effect until IDLE. There is at most one outstanding transaction in total.
- Reset asserted mid-transaction: immediate return to the reset state. Any pending gpio_we is suppressed and no ack is issued. The register file is already reset by the same sys_rst.

Test Plan:
- Write then read, port 0: write addr 0x04, data 0xA5A5_0F0F. gpio_we is high for exactly 1 cycle at t+2 with gpio_addr=0x04. r0_ack at t+3, err=0. Reading 0x04 back returns r0_rdata=0xA5A5_0F0F.
- Contention: r0_req and r1_req both held high continuously for 4 transactions. Grants go 0,1,0,1, acks are spaced 4 cycles apart, and grant_id matches each ack.
- Illegal accesses:
  - Write 0x00 -> no gpio_we, r1_err=1.
  - Read 0x28 -> r1_err=1, r1_rdata=0.
  - Read 0x06 -> err=1.
  - Following legal read of 0x08 -> err=0.
- Port 0 drops r0_req in SETUP on a write to 0x08 -> the write still happens and r0_ack still pulses. The port 1 request pending meanwhile is served next.
- sys_rst pulsed during ACCESS of a write to 0x0C:
  - Outputs go to 0 immediately, no ack, busy=0.
  - After release, a port 0/port 1 tie grants port 0.
- Back-to-back, port 1 alone, 3 reads of 0x00/0x04/0x08: acks at t+3, t+7 and t+11, and r0 outputs remain 0.

Source files
------------

// File: rtl/gpio_access_arbiter.sv
// Round-robin two-port arbiter that sequences each access to the GPIO register
// port as IDLE -> SETUP -> ACCESS -> ACK, rejecting illegal addresses/writes.
module gpio_access_arbiter #(
  parameter logic [31:0] MAX_ADDR = 32'h24,
  parameter logic [31:0] RO_ADDR  = 32'h00
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic        gpio_we,
  output logic [31:0] gpio_addr,
  output logic [31:0] gpio_dat_i,
  input  logic [31:0] gpio_dat_o,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ACK} state_t;

  state_t state;
  logic   last;
  logic   cur_we;
  logic   winner;
  logic   legal;

  // On a tie the port that did not win last time gets the bus.
  always_comb begin
    winner = (r0_req && r1_req) ? ~last : r1_req;
  end

  // gpio_addr doubles as the latched transaction address.
  always_comb begin
    legal = (gpio_addr[1:0] == 2'b00) && (gpio_addr <= MAX_ADDR) &&
            !(cur_we && (gpio_addr == RO_ADDR));
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      last       <= 1'b1;
      cur_we     <= 1'b0;
      grant_id   <= 1'b0;
      busy       <= 1'b0;
      gpio_we    <= 1'b0;
      gpio_addr  <= 32'h0;
      gpio_dat_i <= 32'h0;
      r0_ack     <= 1'b0;
      r0_err     <= 1'b0;
      r0_rdata   <= 32'h0;
      r1_ack     <= 1'b0;
      r1_err     <= 1'b0;
      r1_rdata   <= 32'h0;
    end else begin
      gpio_we <= 1'b0;
      r0_ack  <= 1'b0;
      r1_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            grant_id   <= winner;
            last       <= winner;
            cur_we     <= winner ? r1_we : r0_we;
            gpio_addr  <= winner ? r1_addr : r0_addr;
            gpio_dat_i <= winner ? r1_wdata : r0_wdata;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          gpio_we <= cur_we && legal;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (grant_id) begin
            r1_ack <= 1'b1;
            r1_err <= !legal;
            if (!cur_we) r1_rdata <= legal ? gpio_dat_o : 32'h0;
          end else begin
            r0_ack <= 1'b1;
            r0_err <= !legal;
            if (!cur_we) r0_rdata <= legal ? gpio_dat_o : 32'h0;
          end
          state <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Directed bench for gpio_access_arbiter with a small register-file model
// (0x00 is a fixed input value, 0x04..0x24 are writable).
module tb_gpio_access_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        gpio_we, busy, grant_id;
  logic [31:0] gpio_addr, gpio_dat_i, gpio_dat_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [1:9];
  logic [3:0]  idx;

  always #5 clk = ~clk;

  gpio_access_arbiter dut (
    .sys_clk(clk), .sys_rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .gpio_we(gpio_we), .gpio_addr(gpio_addr), .gpio_dat_i(gpio_dat_i),
    .gpio_dat_o(gpio_dat_o), .busy(busy), .grant_id(grant_id)
  );

  always_comb begin
    idx = gpio_addr[5:2];
    if (idx == 4'd0)      gpio_dat_o = 32'hCAFE_0001;
    else if (idx <= 4'd9) gpio_dat_o = regs[idx];
    else                  gpio_dat_o = 32'h0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= 9; i++) regs[i] <= 32'h0;
    end else if (gpio_we && idx >= 4'd1 && idx <= 4'd9) begin
      regs[idx] <= gpio_dat_i;
    end
  end

  task automatic drive(input bit p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; end
    else   begin r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; end
  endtask

  // Runs one single-port transaction from an IDLE negedge; ends at the next IDLE negedge.
  task automatic run_txn(input bit p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int ack_off,
                         output int we_cnt, output int we_off,
                         output logic [31:0] we_addr, output logic [31:0] we_data,
                         output logic err, output logic [31:0] rdata);
    ack_off = -1; we_cnt = 0; we_off = -1; we_addr = 0; we_data = 0;
    err = 1'bx; rdata = 32'hx;
    drive(p, 1'b1, we, addr, wdata);
    for (int off = 1; off <= 8; off++) begin
      @(posedge clk); @(negedge clk);
      if (gpio_we) begin
        we_cnt++; we_off = off; we_addr = gpio_addr; we_data = gpio_dat_i;
      end
      if ((p ? r1_ack : r0_ack) && ack_off < 0) begin
        ack_off = off;
        err     = p ? r1_err : r0_err;
        rdata   = p ? r1_rdata : r0_rdata;
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
        break;
      end
    end
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checks++;
    if ({r0_ack, r0_err, r1_ack, r1_err, gpio_we, busy, grant_id} !== 7'b0 ||
        r0_rdata !== 0 || r1_rdata !== 0 || gpio_addr !== 0 || gpio_dat_i !== 0) begin
      errors++;
      $display("FAIL reset_state: flags=%b r0_rdata=%h r1_rdata=%h addr=%h dat=%h, required all zero",
               {r0_ack, r0_err, r1_ack, r1_err, gpio_we, busy, grant_id},
               r0_rdata, r1_rdata, gpio_addr, gpio_dat_i);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int ao, wc, wo; logic [31:0] wa, wd, rd; logic e;
    run_txn(0, 1, 32'h04, 32'hA5A5_0F0F, ao, wc, wo, wa, wd, e, rd);
    checks++;
    if (ao !== 3 || wc !== 1 || wo !== 2 || wa !== 32'h04 || wd !== 32'hA5A5_0F0F || e !== 1'b0) begin
      errors++;
      $display("FAIL wr_04: ack_off=%0d we_cnt=%0d we_off=%0d addr=%h data=%h err=%b, required 3 1 2 00000004 a5a50f0f 0",
               ao, wc, wo, wa, wd, e);
    end
    $display("txn p0 write 0x04 ack_off=%0d err=%b", ao, e);
    run_txn(0, 0, 32'h04, 32'h0, ao, wc, wo, wa, wd, e, rd);
    checks++;
    if (ao !== 3 || wc !== 0 || e !== 1'b0 || rd !== 32'hA5A5_0F0F || grant_id !== 1'b0) begin
      errors++;
      $display("FAIL rd_04: ack_off=%0d we_cnt=%0d err=%b rdata=%h grant=%b, required 3 0 0 a5a50f0f 0",
               ao, wc, e, rd, grant_id);
    end
    $display("txn p0 read 0x04 rdata=%h", rd);
  endtask

  task automatic test_drop_req;
    int wc = 0, wo = -1, a0 = -1, a1 = -1; logic [31:0] wa = 0, wd = 0, rd1 = 0; logic e1 = 1'bx;
    drive(0, 1, 1, 32'h08, 32'h0000_1234);
    for (int off = 1; off <= 10; off++) begin
      @(posedge clk); @(negedge clk);
      if (gpio_we) begin wc++; wo = off; wa = gpio_addr; wd = gpio_dat_i; end
      if (r0_ack) a0 = off;
      if (off == 1) begin
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 32'h04, 32'h0);
      end
      if (r1_ack) begin
        a1 = off; rd1 = r1_rdata; e1 = r1_err;
        drive(1, 0, 0, 0, 0);
        break;
      end
    end
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (wc !== 1 || wo !== 2 || wa !== 32'h08 || wd !== 32'h0000_1234 || a0 !== 3) begin
      errors++;
      $display("FAIL drop_write: we_cnt=%0d we_off=%0d addr=%h data=%h r0_ack_off=%0d, required 1 2 00000008 00001234 3",
               wc, wo, wa, wd, a0);
    end
    checks++;
    if (a1 !== 7 || rd1 !== 32'hA5A5_0F0F || e1 !== 1'b0) begin
      errors++;
      $display("FAIL drop_pending_p1: ack_off=%0d rdata=%h err=%b, required 7 a5a50f0f 0", a1, rd1, e1);
    end
    $display("txn p0 write 0x08 (req dropped) ack_off=%0d; p1 read 0x04 ack_off=%0d", a0, a1);
  endtask

  task automatic test_illegal;
    int ao, wc, wo; logic [31:0] wa, wd, rd; logic e;
    run_txn(1, 1, 32'h00, 32'hFFFF_FFFF, ao, wc, wo, wa, wd, e, rd);
    checks++;
    if (ao !== 3 || wc !== 0 || e !== 1'b1 || rd !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL wr_ro: ack_off=%0d we_cnt=%0d err=%b rdata=%h, required 3 0 1 a5a50f0f", ao, wc, e, rd);
    end
    $display("txn p1 write 0x00 err=%b", e);
    run_txn(1, 0, 32'h28, 32'h0, ao, wc, wo, wa, wd, e, rd);
    checks++;
    if (ao !== 3 || e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL rd_28: ack_off=%0d err=%b rdata=%h, required 3 1 00000000", ao, e, rd);
    end
    $display("txn p1 read 0x28 err=%b rdata=%h", e, rd);
    run_txn(1, 0, 32'h06, 32'h0, ao, wc, wo, wa, wd, e, rd);
    checks++;
    if (e !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL rd_06: err=%b rdata=%h, required 1 00000000", e, rd);
    end
    $display("txn p1 read 0x06 err=%b", e);
    run_txn(1, 0, 32'h08, 32'h0, ao, wc, wo, wa, wd, e, rd);
    checks++;
    if (e !== 1'b0 || rd !== 32'h0000_1234) begin
      errors++;
      $display("FAIL rd_08: err=%b rdata=%h, required 0 00001234", e, rd);
    end
    $display("txn p1 read 0x08 err=%b rdata=%h", e, rd);
    run_txn(1, 1, 32'h24, 32'h0000_55AA, ao, wc, wo, wa, wd, e, rd);
    checks++;
    if (wc !== 1 || wa !== 32'h24 || e !== 1'b0) begin
      errors++;
      $display("FAIL wr_24: we_cnt=%0d addr=%h err=%b, required 1 00000024 0", wc, wa, e);
    end
    run_txn(1, 0, 32'h24, 32'h0, ao, wc, wo, wa, wd, e, rd);
    checks++;
    if (e !== 1'b0 || rd !== 32'h0000_55AA) begin
      errors++;
      $display("FAIL rd_24: err=%b rdata=%h, required 0 000055aa", e, rd);
    end
    $display("txn p1 write/read 0x24 rdata=%h", rd);
  endtask

  task automatic test_contention;
    int n = 0; int port_l [4]; int off_l [4]; int gid_l [4];
    drive(0, 1, 0, 32'h04, 32'h0);
    drive(1, 1, 0, 32'h00, 32'h0);
    for (int off = 1; off <= 15; off++) begin
      @(posedge clk); @(negedge clk);
      if ((r0_ack || r1_ack) && n < 4) begin
        port_l[n] = r1_ack ? 1 : 0; off_l[n] = off; gid_l[n] = int'(grant_id); n++;
      end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL contention_count: acks=%0d, required 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (port_l[i] !== i % 2 || off_l[i] !== 3 + 4 * i || gid_l[i] !== i % 2) begin
        errors++;
        $display("FAIL contention_%0d: port=%0d off=%0d grant=%0d, required %0d %0d %0d",
                 i, port_l[i], off_l[i], gid_l[i], i % 2, 3 + 4 * i, i % 2);
      end
      $display("txn contention ack %0d port=%0d off=%0d", i, port_l[i], off_l[i]);
    end
    checks++;
    if (r0_rdata !== 32'hA5A5_0F0F || r1_rdata !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL contention_rdata: r0=%h r1=%h, required a5a50f0f cafe0001", r0_rdata, r1_rdata);
    end
  endtask

  task automatic test_reset_mid;
    logic we_seen = 1'b0; int bad_acks = 0; int a0 = -1, a1 = -1; logic g0 = 1'bx;
    drive(0, 1, 1, 32'h0C, 32'h0000_DEAD);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    we_seen = gpio_we;
    rst = 1'b1;
    #1;
    checks++;
    if (we_seen !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: gpio_we in ACCESS=%b, required 1", we_seen);
    end
    checks++;
    if ({r0_ack, r0_err, r1_ack, r1_err, gpio_we, busy, grant_id} !== 7'b0 ||
        r0_rdata !== 0 || r1_rdata !== 0 || gpio_addr !== 0 || gpio_dat_i !== 0) begin
      errors++;
      $display("FAIL rst_mid_outputs: flags=%b r0=%h r1=%h addr=%h dat=%h, required all zero",
               {r0_ack, r0_err, r1_ack, r1_err, gpio_we, busy, grant_id},
               r0_rdata, r1_rdata, gpio_addr, gpio_dat_i);
    end
    drive(0, 0, 0, 0, 0);
    repeat (2) begin
      @(negedge clk);
      if (r0_ack || r1_ack || gpio_we) bad_acks++;
    end
    rst = 1'b0;
    @(negedge clk);
    if (r0_ack || r1_ack) bad_acks++;
    checks++;
    if (bad_acks !== 0) begin
      errors++;
      $display("FAIL rst_mid_noack: stray pulses=%0d, required 0", bad_acks);
    end
    drive(0, 1, 0, 32'h0C, 32'h0);
    drive(1, 1, 0, 32'h00, 32'h0);
    for (int off = 1; off <= 10; off++) begin
      @(posedge clk); @(negedge clk);
      if (r0_ack) begin a0 = off; g0 = grant_id; drive(0, 0, 0, 0, 0); end
      if (r1_ack) begin a1 = off; drive(1, 0, 0, 0, 0); break; end
    end
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (a0 !== 3 || g0 !== 1'b0 || a1 !== 7 || r0_rdata !== 32'h0 || r0_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_tie: r0_off=%0d grant=%b r1_off=%0d r0_rdata=%h r0_err=%b, required 3 0 7 00000000 0",
               a0, g0, a1, r0_rdata, r0_err);
    end
    $display("txn post-reset tie r0_off=%0d r1_off=%0d", a0, a1);
  endtask

  task automatic test_back_to_back;
    int n = 0; int offs [3]; logic [31:0] rds [3]; int r0_pulses = 0;
    logic [31:0] addrs [3];
    logic [31:0] exp_rd [3];
    addrs[0] = 32'h00; addrs[1] = 32'h04; addrs[2] = 32'h08;
    exp_rd[0] = 32'hCAFE_0001; exp_rd[1] = 32'h0; exp_rd[2] = 32'h0;
    drive(1, 1, 0, addrs[0], 32'h0);
    for (int off = 1; off <= 12; off++) begin
      @(posedge clk); @(negedge clk);
      if (r0_ack) r0_pulses++;
      if (r1_ack && n < 3) begin
        offs[n] = off; rds[n] = r1_rdata; n++;
        if (n < 3) drive(1, 1, 0, addrs[n], 32'h0);
        else       drive(1, 0, 0, 0, 0);
      end
    end
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL b2b_count: acks=%0d, required 3", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (offs[i] !== 3 + 4 * i || rds[i] !== exp_rd[i]) begin
        errors++;
        $display("FAIL b2b_%0d: off=%0d rdata=%h, required %0d %h", i, offs[i], rds[i], 3 + 4 * i, exp_rd[i]);
      end
      $display("txn b2b p1 read %h off=%0d rdata=%h", addrs[i], offs[i], rds[i]);
    end
    checks++;
    if (r0_pulses !== 0 || r0_rdata !== 32'h0 || r0_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_r0_quiet: r0_acks=%0d r0_rdata=%h r0_err=%b, required 0 00000000 0",
               r0_pulses, r0_rdata, r0_err);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_drop_req;
    test_illegal;
    test_contention;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
